axi_setting_writer: RTL and testbench
=====================================

# axi_setting_writer

Stream-to-settings-bus writer: consumes AXI-stream command packets and issues `set_stb`/`set_addr`/`set_data` writes on the settings bus. It is the producer side of the settings bus that per-register stream endpoints consume. It sits between a control-packet demux (host or CPU command stream) and the block's settings bus. It supports burst writes with optional address auto-increment, programmable strobe spacing for slow consumers, and framing-error recovery.

## Interface
- `AWIDTH`, 8: settings address width (1..16).
- `STB_GAP`, 0: minimum idle cycles between consecutive `set_stb` pulses (0..255).
- `clk`  in  1  clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `i_tdata`  in  32  command/data word.
- `i_tlast`  in  1  marks last word of a packet.
- `i_tvalid`  in  1  input valid.
- `i_tready`  out  1  input ready.
- `set_stb`  out  1  one-cycle write strobe.
- `set_addr`  out  AWIDTH  write address.
- `set_data`  out  32  write data.
- `busy`  out  1  high while a packet is in progress (state ≠ HDR).
- `err_stb`  out  1  one-cycle pulse per framing error.
- `err_cnt`  out  16  framing-error count, saturates at 0xFFFF.

## Operation
- Packet format:
  - Header word: `[AWIDTH-1:0]` base address; `[23:16]` N-1, where N = 1..256 data words; `[31]` INC (1 = auto-increment). All other bits are ignored.
  - Header is followed by N data words. `i_tlast` is required on data word N only.
- Handshake: a word transfers when `i_tvalid & i_tready`.
- States:
  - HDR: `i_tready`=1. On transfer, latch base/N/INC, clear word index k, go to DATA. If `i_tlast` is set on the header: error, stay in HDR.
  - DATA: `i_tready`=1 only when the gap counter is 0. Each transfer issues a write of that word to address base+k if INC=1, else base; k increments.
    - Word N with `i_tlast` → HDR.
    - Word N without `i_tlast` → error, go to DRAIN.
    - Word k<N with `i_tlast` → the write is still issued, then error, go to HDR.
  - DRAIN: `i_tready`=1. Discard words until a transfer with `i_tlast`, then go to HDR. No writes are issued.
- Address arithmetic is modulo 2^AWIDTH; wrap-around is silent, not an error.
- Gap counter: loaded with STB_GAP on every write and decremented to 0 each cycle. It holds off `i_tready` only in DATA. With STB_GAP=0, `i_tready` stays high in DATA.
- Error handling:
  - Each error pulses `err_stb` for one cycle, registered one cycle after the offending transfer.
  - Each error increments `err_cnt`, saturating at 0xFFFF.
  - An error never suppresses a write already accepted.

## Timing
- Reset values, held while `reset_n`=0: `set_stb`=0, `set_addr`=0, `set_data`=0, `i_tready`=0, `busy`=0, `err_stb`=0, `err_cnt`=0, state=HDR, gap counter=0.
  - `i_tready` rises the first cycle after reset release.
- Write latency: a data transfer in cycle t produces `set_stb`=1 in cycle t+1, with `set_addr`/`set_data` valid in that cycle.
  - `set_addr`/`set_data` hold their last values while `set_stb`=0.
- Throughput:
  - STB_GAP=0: one write per cycle, back-to-back.
  - STB_GAP=G: consecutive strobes are at least G+1 cycles apart.
  - The header costs one cycle with no strobe.
- `busy` is registered from the state: high from the cycle after header acceptance until the cycle after the packet-ending transfer.
- Reset mid-packet returns to HDR; the partial packet is abandoned with no error counted, and the next word after reset is parsed as a header.
- Simultaneous error and increment at `err_cnt`=0xFFFF: the counter stays at 0xFFFF and `err_stb` still pulses.

## Structure
- Shared package `axi_setting_writer_pkg`:
  - state enum (HDR, DATA, DRAIN);
  - header field constants: `HDR_INC_BIT`=31, `HDR_LEN_MSB`=23, `HDR_LEN_LSB`=16.
- Single module, no sub-modules. The gap counter and error counter are inline processes.

## Test plan
- Back-to-back burst: STB_GAP=0, header addr 0x10, N=3, INC=1, data 0xA,0xB,0xC with `i_tlast` on 0xC → three consecutive strobes at addr 0x10/0x11/0x12 with data 0xA/0xB/0xC; `err_cnt`=0.
- No increment and wrap-around:
  - INC=0, base 0x20, N=2 → both writes at 0x20.
  - INC=1, base 0xFE, N=4 → writes at 0xFE,0xFF,0x00,0x01.
- Early `i_tlast`: N=4, `i_tlast` on data word 2 → two writes, one `err_stb` pulse, `err_cnt`=1; the next word is accepted as a header and its packet executes normally.
- Missing `i_tlast`: N=2, four data words with `i_tlast` on the 4th → two writes only; words 3-4 are dropped; `err_cnt`=1; `busy` falls after word 4.
- Throttling: STB_GAP=2, N=4, `i_tvalid` held high → strobes exactly 3 cycles apart and `i_tready` low for 2 cycles after each write.
- Reset and header-only framing:
  - Assert `reset_n`=0 for one cycle after data word 1 of an N=3 packet → all outputs at reset values; the next word is parsed as a header.
  - A header with `i_tlast`=1 → no write, `err_cnt` increments by 1.

Source files
------------

// File: rtl/axi_setting_writer_pkg.sv
// Shared types and header field positions for the stream-to-settings-bus writer.
package axi_setting_writer_pkg;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int HDR_INC_BIT = 31;
    localparam int HDR_LEN_MSB = 23;
    localparam int HDR_LEN_LSB = 16;

    localparam int GAP_W = 8;
    localparam int ERR_W = 16;

endpackage

// File: rtl/axi_setting_writer.sv
// Consumes AXI-stream command packets (header + N data words) and issues
// settings-bus writes with optional address auto-increment and strobe spacing.
module axi_setting_writer
    import axi_setting_writer_pkg::*;
#(
    parameter int AWIDTH  = 8,
    parameter int STB_GAP = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       i_tdata,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic              set_stb,
    output logic [AWIDTH-1:0] set_addr,
    output logic [31:0]       set_data,
    output logic              busy,
    output logic              err_stb,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(STB_GAP);

    state_t            state, state_next;
    logic              run_en;
    logic [AWIDTH-1:0] base;
    logic [7:0]        len;
    logic [7:0]        idx;
    logic              inc;
    logic [GAP_W-1:0]  gap_cnt;
    logic              xfer;
    logic              hdr_fire;
    logic              wr_fire;
    logic              err_fire;
    logic              idx_step;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_next = state;
        i_tready   = 1'b0;
        hdr_fire   = 1'b0;
        wr_fire    = 1'b0;
        err_fire   = 1'b0;
        idx_step   = 1'b0;

        case (state)
            HDR:     i_tready = run_en;
            DATA:    i_tready = run_en && (gap_cnt == '0);
            DRAIN:   i_tready = run_en;
            default: i_tready = 1'b0;
        endcase

        xfer = i_tvalid && i_tready;

        if (xfer) begin
            case (state)
                HDR: begin
                    if (i_tlast) begin
                        err_fire = 1'b1;
                    end else begin
                        hdr_fire   = 1'b1;
                        state_next = DATA;
                    end
                end
                DATA: begin
                    // A word is always written once accepted, even if it ends the packet badly.
                    wr_fire = 1'b1;
                    if (idx == len) begin
                        if (i_tlast) begin
                            state_next = HDR;
                        end else begin
                            err_fire   = 1'b1;
                            state_next = DRAIN;
                        end
                    end else if (i_tlast) begin
                        err_fire   = 1'b1;
                        state_next = HDR;
                    end else begin
                        idx_step = 1'b1;
                    end
                end
                DRAIN: begin
                    if (i_tlast) state_next = HDR;
                end
                default: state_next = HDR;
            endcase
        end
    end

    // run_en keeps i_tready low until the first cycle after reset release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= HDR;
            run_en <= 1'b0;
            busy   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state  <= state_next;
            run_en <= 1'b1;
            busy   <= (state_next != HDR);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base     <= '0;
            len      <= '0;
            inc      <= 1'b0;
            idx      <= '0;
            set_stb  <= 1'b0;
            set_addr <= '0;
            set_data <= '0;
        end else begin
            set_stb <= wr_fire;
            if (hdr_fire) begin
                base <= i_tdata[AWIDTH-1:0];
                len  <= i_tdata[HDR_LEN_MSB:HDR_LEN_LSB];
                inc  <= i_tdata[HDR_INC_BIT];
                idx  <= '0;
            end else if (idx_step) begin
                idx <= idx + 8'd1;
            end
            if (wr_fire) begin
                // Address wraps modulo 2^AWIDTH by truncation.
                set_addr <= inc ? base + AWIDTH'(idx) : base;
                set_data <= i_tdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (wr_fire) begin
            gap_cnt <= GAP_LOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_stb <= 1'b0;
            err_cnt <= '0;
        end else begin
            err_stb <= err_fire;
            if (err_fire && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_setting_writer.sv
// Bench for axi_setting_writer: two instances (strobe gap 0 and 2) checked every
// cycle against a packet-level reference model, plus directed literal checks.
module tb_axi_setting_writer;

    localparam int G1 = 2;

    typedef struct {
        int          d;
        logic [7:0]  a;
        logic [31:0] v;
        int          c;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] tdata;
    logic        tlast;
    logic [1:0]  vld;
    logic [1:0]  rdy;
    logic [1:0]  stb;
    logic [7:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [1:0]  bsy;
    logic [1:0]  est;
    logic [15:0] ecnt  [2];

    int n_checks = 0;
    int n_err    = 0;

    // reference model state and expected outputs, one slot per instance
    int        edge_cnt = 0;
    int        m_mode    [2];
    int        m_n       [2];
    int        m_k       [2];
    int        m_base    [2];
    bit        m_inc     [2];
    int        m_last_wr [2];
    bit        e_stb     [2];
    bit [7:0]  e_addr    [2];
    bit [31:0] e_data    [2];
    bit        e_busy    [2];
    bit        e_err     [2];
    bit        e_rdy     [2];
    bit [15:0] e_cnt     [2];

    wr_t log_q[$];
    int  err_pulses = 0;
    int  low_cnt    = 0;

    axi_setting_writer #(.AWIDTH(8), .STB_GAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(vld[0]), .i_tready(rdy[0]),
        .set_stb(stb[0]), .set_addr(addr[0]), .set_data(wdata[0]),
        .busy(bsy[0]), .err_stb(est[0]), .err_cnt(ecnt[0])
    );

    axi_setting_writer #(.AWIDTH(8), .STB_GAP(G1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(vld[1]), .i_tready(rdy[1]),
        .set_stb(stb[1]), .set_addr(addr[1]), .set_data(wdata[1]),
        .busy(bsy[1]), .err_stb(est[1]), .err_cnt(ecnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] @%0t: got 0x%0h, expected 0x%0h", name, d, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [7:0] a, input int n, input logic inc);
        return {inc, 7'd0, 8'(n - 1), 8'd0, a};
    endfunction

    // Packet-level model: one call per clock edge per instance.
    task automatic model_edge(input int d);
        bit x;
        int gap;
        x   = vld[d] && e_rdy[d];
        gap = (d == 0) ? 0 : G1;
        e_stb[d] = 1'b0;
        e_err[d] = 1'b0;
        if (!reset_n) begin
            m_mode[d]    = 0;
            m_last_wr[d] = -1000;
            e_addr[d]    = '0;
            e_data[d]    = '0;
            e_cnt[d]     = '0;
            e_busy[d]    = 1'b0;
            e_rdy[d]     = 1'b0;
            return;
        end
        if (x) begin
            if (m_mode[d] == 0) begin
                if (tlast) begin
                    e_err[d] = 1'b1;
                end else begin
                    m_base[d] = int'(tdata[7:0]);
                    m_n[d]    = int'(tdata[23:16]) + 1;
                    m_inc[d]  = tdata[31];
                    m_k[d]    = 0;
                    m_mode[d] = 1;
                end
            end else if (m_mode[d] == 1) begin
                e_stb[d]     = 1'b1;
                e_addr[d]    = 8'((m_base[d] + (m_inc[d] ? m_k[d] : 0)) % 256);
                e_data[d]    = tdata;
                m_last_wr[d] = edge_cnt;
                m_k[d]++;
                if (m_k[d] == m_n[d]) begin
                    m_mode[d] = tlast ? 0 : 2;
                    e_err[d]  = !tlast;
                end else if (tlast) begin
                    m_mode[d] = 0;
                    e_err[d]  = 1'b1;
                end
            end else if (tlast) begin
                m_mode[d] = 0;
            end
        end
        if (e_err[d] && e_cnt[d] != 16'hFFFF) e_cnt[d]++;
        e_busy[d] = (m_mode[d] != 0);
        e_rdy[d]  = (m_mode[d] != 1) || (edge_cnt - m_last_wr[d] >= gap);
    endtask

    always @(posedge clk) begin
        edge_cnt++;
        model_edge(0);
        model_edge(1);
    end

    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            for (int d = 0; d < 2; d++) begin
                check("tready",   d, 32'(rdy[d]),   32'(e_rdy[d]));
                check("set_stb",  d, 32'(stb[d]),   32'(e_stb[d]));
                check("set_addr", d, 32'(addr[d]),  32'(e_addr[d]));
                check("set_data", d, wdata[d],      e_data[d]);
                check("busy",     d, 32'(bsy[d]),   32'(e_busy[d]));
                check("err_stb",  d, 32'(est[d]),   32'(e_err[d]));
                check("err_cnt",  d, 32'(ecnt[d]),  32'(e_cnt[d]));
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (stb[d] === 1'b1) log_q.push_back('{d, addr[d], wdata[d], edge_cnt});
            if (est[d] === 1'b1) err_pulses++;
        end
        if (reset_n && rdy[1] === 1'b0) low_cnt++;
    end

    // Tasks start and end just after a falling edge; valid is left high for back-to-back words.
    task automatic send(input int d, input logic [31:0] w, input logic last);
        int waited;
        tdata  = w;
        tlast  = last;
        vld[d] = 1'b1;
        waited = 0;
        while (rdy[d] !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 64) begin
            n_checks++;
            n_err++;
            $display("FAIL handshake_timeout[%0d] @%0t: tready never rose within 64 cycles", d, $time);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        vld   = 2'b00;
        tlast = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_wr(input int idx, input logic [7:0] a, input logic [31:0] v);
        if (idx < log_q.size()) begin
            check("wr_addr", idx, 32'(log_q[idx].a), 32'(a));
            check("wr_data", idx, log_q[idx].v, v);
        end else begin
            check("wr_missing", idx, log_q.size(), idx + 1);
        end
    endtask

    task automatic chk_spacing(input int idx, input int exp);
        if (idx + 1 < log_q.size()) check("wr_spacing", idx, log_q[idx + 1].c - log_q[idx].c, exp);
        else check("wr_missing", idx + 1, log_q.size(), idx + 2);
    endtask

    task automatic maybe_idle();
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    endtask

    task automatic rand_pkt(input int d);
        int          n;
        int          kind;
        int          total;
        logic [31:0] h;
        n    = $urandom_range(1, 6);
        kind = $urandom_range(0, 9);
        h    = hdr(8'($urandom), n, 1'($urandom)) | ($urandom & 32'h7F00FF00);
        if (kind == 0) begin
            send(d, h, 1'b1);
            maybe_idle();
            return;
        end
        send(d, h, 1'b0);
        maybe_idle();
        if (kind == 1 && n > 1) total = $urandom_range(1, n - 1);
        else if (kind == 2) total = n + $urandom_range(1, 3);
        else total = n;
        for (int i = 1; i <= total; i++) begin
            send(d, $urandom, (i == total) ? 1'b1 : 1'b0);
            maybe_idle();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        tdata   = '0;
        tlast   = 1'b0;
        vld     = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_tready", 0, 32'(rdy[0]), 0);
        check("rst_err_cnt", 0, 32'(ecnt[0]), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // back-to-back burst with increment
        log_q.delete();
        send(0, hdr(8'h10, 3, 1'b1), 1'b0);
        send(0, 32'hA, 1'b0);
        send(0, 32'hB, 1'b0);
        send(0, 32'hC, 1'b1);
        idle(3);
        check("t1_count", 0, log_q.size(), 3);
        chk_wr(0, 8'h10, 32'hA);
        chk_wr(1, 8'h11, 32'hB);
        chk_wr(2, 8'h12, 32'hC);
        chk_spacing(0, 1);
        chk_spacing(1, 1);
        check("t1_err_cnt", 0, 32'(ecnt[0]), 0);

        // fixed address, then increment across the wrap
        log_q.delete();
        send(0, hdr(8'h20, 2, 1'b0), 1'b0);
        send(0, 32'h1111, 1'b0);
        send(0, 32'h2222, 1'b1);
        send(0, hdr(8'hFE, 4, 1'b1), 1'b0);
        send(0, 32'h3, 1'b0);
        send(0, 32'h4, 1'b0);
        send(0, 32'h5, 1'b0);
        send(0, 32'h6, 1'b1);
        idle(3);
        check("t2_count", 0, log_q.size(), 6);
        chk_wr(0, 8'h20, 32'h1111);
        chk_wr(1, 8'h20, 32'h2222);
        chk_wr(2, 8'hFE, 32'h3);
        chk_wr(3, 8'hFF, 32'h4);
        chk_wr(4, 8'h00, 32'h5);
        chk_wr(5, 8'h01, 32'h6);

        // early tlast, then a normal packet
        log_q.delete();
        err_pulses = 0;
        send(0, hdr(8'h40, 4, 1'b1), 1'b0);
        send(0, 32'hE1, 1'b0);
        send(0, 32'hE2, 1'b1);
        idle(3);
        check("t3_count", 0, log_q.size(), 2);
        check("t3_err_cnt", 0, 32'(ecnt[0]), 1);
        check("t3_err_pulses", 0, err_pulses, 1);
        send(0, hdr(8'h50, 1, 1'b1), 1'b0);
        send(0, 32'h77, 1'b1);
        idle(3);
        check("t3_next_count", 0, log_q.size(), 3);
        chk_wr(2, 8'h50, 32'h77);
        check("t3_err_cnt_after", 0, 32'(ecnt[0]), 1);

        // missing tlast: extra words are drained
        log_q.delete();
        send(0, hdr(8'h60, 2, 1'b1), 1'b0);
        send(0, 32'hD1, 1'b0);
        send(0, 32'hD2, 1'b0);
        send(0, 32'hD3, 1'b0);
        check("t4_busy_drain", 0, 32'(bsy[0]), 1);
        send(0, 32'hD4, 1'b1);
        check("t4_busy_after", 0, 32'(bsy[0]), 0);
        idle(3);
        check("t4_count", 0, log_q.size(), 2);
        chk_wr(1, 8'h61, 32'hD2);
        check("t4_err_cnt", 0, 32'(ecnt[0]), 2);

        // throttled instance, valid held high
        log_q.delete();
        low_cnt = 0;
        send(1, hdr(8'h80, 4, 1'b1), 1'b0);
        send(1, 32'hF0, 1'b0);
        send(1, 32'hF1, 1'b0);
        send(1, 32'hF2, 1'b0);
        send(1, 32'hF3, 1'b1);
        idle(3);
        check("t5_count", 1, log_q.size(), 4);
        chk_wr(3, 8'h83, 32'hF3);
        chk_spacing(0, G1 + 1);
        chk_spacing(1, G1 + 1);
        chk_spacing(2, G1 + 1);
        check("t5_ready_low", 1, low_cnt, 3 * G1);
        check("t5_err_cnt", 1, 32'(ecnt[1]), 0);

        // reset mid-packet
        log_q.delete();
        send(0, hdr(8'h90, 3, 1'b1), 1'b0);
        send(0, 32'h9, 1'b0);
        vld     = 2'b00;
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_rst_tready", 0, 32'(rdy[0]), 0);
        check("t6_rst_stb", 0, 32'(stb[0]), 0);
        check("t6_rst_addr", 0, 32'(addr[0]), 0);
        check("t6_rst_data", 0, wdata[0], 0);
        check("t6_rst_busy", 0, 32'(bsy[0]), 0);
        check("t6_rst_err_cnt", 0, 32'(ecnt[0]), 0);
        reset_n = 1'b1;
        send(0, hdr(8'h33, 1, 1'b1), 1'b0);
        send(0, 32'h55, 1'b1);
        idle(3);
        check("t6_count", 0, log_q.size(), 2);
        chk_wr(1, 8'h33, 32'h55);
        check("t6_err_cnt", 0, 32'(ecnt[0]), 0);

        // header carrying tlast
        send(0, hdr(8'hAA, 2, 1'b1), 1'b1);
        idle(3);
        check("t7_count", 0, log_q.size(), 2);
        check("t7_err_cnt", 0, 32'(ecnt[0]), 1);

        for (int p = 0; p < 60; p++) rand_pkt($urandom_range(0, 1));
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
